mips_mem_dump: RTL and testbench
================================

// Module: mips_mem_dump
// PURPOSE
//  Hardware read-back engine for the pipelined MIPS32 data memory; the reader counterpart of the bench/loader that writes Mem[].
//  On a start pulse, it reads a contiguous word range through a 1-cycle-latency synchronous read port.
//  It streams {address, data} beats out over a valid/ready interface, buffered against backpressure.
//  It sits beside the core and is used after HALTED to extract results such as Mem[198], with no hierarchical peeking.
// PARAMETERS
//  AW  10  memory word-address width (1024-word Mem)
//  DW  32  data word width
// PORTS
//  clk1         in   1     clock; all state updates on posedge
//  rst_n        in   1     async active-low reset
//  start        in   1     1-cycle request; sampled only in IDLE
//  base_addr    in   AW    first word address; captured on accepted start
//  word_count   in   AW+1  number of words to dump, 0..2^AW; captured on accepted start
//  busy         out  1     high from the cycle after an accepted start until done
//  done         out  1     1-cycle pulse when the dump completes
//  mem_rd_en    out  1     read strobe to the memory port
//  mem_addr     out  AW    read address
//  mem_rd_data  in   DW    read data, valid the cycle after mem_rd_en
//  out_valid    out  1     beat available
//  out_ready    in   1     sink accepts; a transfer occurs when valid&&ready on posedge
//  out_addr     out  AW    address of the beat's word
//  out_data     out  DW    word data
//  out_last     out  1     marks the final beat of the dump
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; FIFO empty; counters 0. Reset mid-dump aborts at once, with no done pulse.
//  FSM states: IDLE -> READ -> DRAIN -> IDLE.
//   IDLE: start=1 captures base_addr and word_count, then moves to READ.
//   IDLE with word_count=0 goes straight to the done pulse; no beats are emitted (see CONFIGURATION for the exception).
//   READ: issues mem_rd_en with mem_addr = base + issued_cnt, but only when (fifo_cnt + inflight) < 2.
//   READ -> DRAIN once issued_cnt == word_count.
//   DRAIN: waits for FIFO empty and no read in flight. It then pulses done and returns to IDLE.
//  Skid buffer: 2-entry FIFO holding {addr, data}. Read data is written the cycle after mem_rd_en.
//   Overflow is impossible by the issue rule. With out_ready held at 1, one read is issued every cycle.
//  Latency: start at edge N gives mem_rd_en high during cycle N+1 and the first out_valid during cycle N+2.
//   With out_ready=1, throughput is 1 beat/cycle.
//  done asserts in the cycle after the last handshake; busy drops in the same cycle.
//  Address arithmetic: modulo 2^AW; the address after 2^AW-1 is 0. issued_cnt and sent_cnt are AW+1 bits wide.
//  out_last = out_valid && (sent_cnt == word_count-1), i.e. true on the final data beat.
//  out_valid must hold, and out_addr/out_data must stay stable, until the beat is accepted.
//  A start received while busy is ignored; the captured parameters stay unchanged.
//  If start coincides with done, start is ignored, because the FSM is not yet in IDLE.
//  mem_rd_en is 0 outside READ. mem_addr holds its last value when idle.
// CONFIGURATION
//  MEM_DUMP_CHKSUM_EN defined:
//   - After the last data beat, one extra beat is emitted. Its out_addr = base+word_count (mod 2^AW).
//   - Its out_data is the DW-bit modulo-2^DW sum of all data words, and out_last is asserted on this beat only.
//   - word_count=0 emits one checksum beat with data 0.
//  MEM_DUMP_CHKSUM_EN undefined: no sum logic and no extra beat; out_last is on the final data beat.
// TESTING
//  1 Mem[198]=5040, Mem[199]=0, Mem[200]=7; base=198, count=3, ready=1
//    -> beats (198,5040), (199,0), (200,7); last on the 3rd beat; done 1 cycle later.
//  2 Same as 1, but ready toggles 1,0,0,1,...
//    -> identical beat sequence, none lost or duplicated; data stable while stalled; mem_rd_en never leaves more than 2 words outstanding.
//  3 base=1023, count=2 with Mem[1023]=0xAAAA0000 and Mem[0]=0x280A00C8
//    -> beats (1023,0xAAAA0000) then (0,0x280A00C8).
//  4 count=0 -> done 2 cycles after start and no out_valid; with CHKSUM_EN, a single beat (base,0) with last.
//  5 rst_n low after 2 beats of a count=8 dump -> all outputs 0 asynchronously, no done pulse.
//    A fresh start then dumps from base again.
//  6 CHKSUM_EN, test 1 data -> 4th beat (201,5047) with last.
//    A start pulse issued mid-dump is ignored, with no change to the beat sequence.

Source files
------------

// File: rtl/mips_mem_dump.sv
// Read-back engine: streams {addr, data} beats from a 1-cycle-latency memory port over valid/ready.
// Optional MEM_DUMP_CHKSUM_EN appends a checksum beat carrying the modulo-2^DW sum of the data words.
module mips_mem_dump #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] base_addr,
    input  logic [AW:0]   word_count,
    output logic          busy,
    output logic          done,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rd_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_addr,
    output logic [DW-1:0] out_data,
    output logic          out_last
);

    typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

    state_e        state_q;
    logic [AW-1:0] base_q, last_addr_q, infl_addr_q;
    logic [AW:0]   count_q, issued_q, sent_q;
    logic          infl_q, busy_q, done_q;
    logic [AW+DW-1:0] fifo_q [2];
    logic          wr_ptr_q, rd_ptr_q;
    logic [1:0]    fifo_cnt_q;
`ifdef MEM_DUMP_CHKSUM_EN
    logic [DW-1:0] sum_q;
    logic          chk_valid;
`endif

    logic          data_valid, data_pop, issue, accept, fifo_push, fifo_rd, finish;
    logic [AW-1:0] data_addr, next_addr;
    logic [DW-1:0] data_word;
    logic [AW+DW-1:0] fifo_head;
    logic [2:0]    occ, occ_next;

    // With the FIFO empty, the word arriving from memory is presented directly (bypass).
    assign fifo_head  = fifo_q[rd_ptr_q];
    assign data_valid = (fifo_cnt_q != 2'd0) || infl_q;
    assign data_addr  = (fifo_cnt_q != 2'd0) ? fifo_head[AW+DW-1:DW] : infl_addr_q;
    assign data_word  = (fifo_cnt_q != 2'd0) ? fifo_head[DW-1:0] : mem_rd_data;
    assign data_pop   = data_valid && out_ready;

    // Occupancy counts buffered plus in-flight words, net of this cycle's pop.
    assign occ       = 3'(fifo_cnt_q) + 3'(infl_q);
    assign occ_next  = occ - 3'(data_pop);
    assign next_addr = base_q + issued_q[AW-1:0];
    assign issue     = (state_q == StRead) && (issued_q != count_q) && (occ_next < 3'd2);
    assign accept    = (state_q == StIdle) && start && !done_q;
    assign fifo_push = infl_q && !((fifo_cnt_q == 2'd0) && data_pop);
    assign fifo_rd   = data_pop && (fifo_cnt_q != 2'd0);

    assign mem_rd_en = issue;
    assign mem_addr  = (state_q == StRead) ? next_addr : last_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;

    always_comb begin
        out_valid = 1'b0;
        out_addr  = '0;
        out_data  = '0;
        out_last  = 1'b0;
        finish    = 1'b0;
`ifdef MEM_DUMP_CHKSUM_EN
        chk_valid = (state_q == StDrain) && !data_valid && (sent_q == count_q);
        out_valid = data_valid || chk_valid;
        out_last  = chk_valid;
        if (data_valid) begin
            out_addr = data_addr;
            out_data = data_word;
        end else if (chk_valid) begin
            out_addr = base_q + count_q[AW-1:0];
            out_data = sum_q;
        end
        finish = chk_valid && out_ready;
`else
        out_valid = data_valid;
        out_last  = data_valid && (sent_q == count_q - (AW+1)'(1));
        if (data_valid) begin
            out_addr = data_addr;
            out_data = data_word;
        end
        finish = (state_q == StDrain) && (occ_next == 3'd0);
`endif
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            base_q      <= '0;
            count_q     <= '0;
            issued_q    <= '0;
            sent_q      <= '0;
            infl_q      <= 1'b0;
            infl_addr_q <= '0;
            last_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_cnt_q  <= '0;
            fifo_q[0]   <= '0;
            fifo_q[1]   <= '0;
`ifdef MEM_DUMP_CHKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            infl_q <= issue;
            if (fifo_push) begin
                fifo_q[wr_ptr_q] <= {infl_addr_q, mem_rd_data};
                wr_ptr_q         <= ~wr_ptr_q;
            end
            if (fifo_rd) rd_ptr_q <= ~rd_ptr_q;
            fifo_cnt_q <= fifo_cnt_q + 2'(fifo_push) - 2'(fifo_rd);
            if (issue) begin
                infl_addr_q <= next_addr;
                last_addr_q <= next_addr;
                issued_q    <= issued_q + (AW+1)'(1);
            end
            if (data_pop) begin
                sent_q <= sent_q + (AW+1)'(1);
`ifdef MEM_DUMP_CHKSUM_EN
                sum_q  <= sum_q + data_word;
`endif
            end
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        base_q   <= base_addr;
                        count_q  <= word_count;
                        issued_q <= '0;
                        sent_q   <= '0;
                        busy_q   <= 1'b1;
`ifdef MEM_DUMP_CHKSUM_EN
                        sum_q    <= '0;
`endif
                        state_q  <= (word_count == '0) ? StDrain : StRead;
                    end
                end
                StRead: begin
                    // Leave on the final issue so done can follow the last handshake directly.
                    if (issue && (issued_q + (AW+1)'(1) == count_q)) state_q <= StDrain;
                end
                StDrain: begin
                    if (finish) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_mem_dump.sv
// Directed bench for mips_mem_dump: hand-computed beat sequences, stall, wrap, empty and reset cases.
// Honours MEM_DUMP_CHKSUM_EN when the design is built with it.
module tb_mips_mem_dump;
    logic        clk1 = 1'b0;
    logic        rst_n, start, busy, done, mem_rd_en, out_valid, out_ready, out_last;
    logic [9:0]  base_addr, mem_addr, out_addr;
    logic [10:0] word_count;
    logic [31:0] mem_rd_data, out_data;

    logic [31:0] mem [1024];
    logic [9:0]  exp_addr [16];
    logic [31:0] exp_data [16];
    int n_checks = 0;
    int n_fail   = 0;

`ifdef MEM_DUMP_CHKSUM_EN
    localparam int ChkExtra = 1;
`else
    localparam int ChkExtra = 0;
`endif

    mips_mem_dump #(.AW(10), .DW(32)) dut (
        .clk1(clk1), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_count(word_count), .busy(busy), .done(done), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_rd_data(mem_rd_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_addr(out_addr), .out_data(out_data), .out_last(out_last)
    );

    always #5 clk1 = ~clk1;

    always @(posedge clk1) if (mem_rd_en) mem_rd_data <= mem[mem_addr];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // rmode 0: ready held high; rmode 1: ready pattern 1,0,0,1 repeating.
    task automatic run_dump(input string tag, input logic [9:0] b, input logic [10:0] n,
                            input int rmode, input int nbeats, input int exp_done,
                            input bit mid_start);
        int cyc = 0, got = 0, issued = 0, max_out = 0, done_cyc = -1;
        bit stalled = 1'b0;
        logic [9:0]  p_addr = '0;
        logic [31:0] p_data = '0;
        @(negedge clk1);
        start = 1'b1; base_addr = b; word_count = n;
        @(negedge clk1);
        start = 1'b0;
        while (done_cyc < 0 && cyc < 100) begin
            out_ready = (rmode == 0) || (cyc % 4 == 0) || (cyc % 4 == 3);
            if (mid_start && cyc == 2) begin
                start = 1'b1; base_addr = 10'd500; word_count = 11'd5;
            end else begin
                start = 1'b0;
            end
            #1;
            if (cyc == 0) check_eq($sformatf("%s busy", tag), 64'(busy), 64'(1));
            if (stalled) begin
                check_eq($sformatf("%s hold valid", tag), 64'(out_valid), 64'(1));
                check_eq($sformatf("%s hold addr", tag), 64'(out_addr), 64'(p_addr));
                check_eq($sformatf("%s hold data", tag), 64'(out_data), 64'(p_data));
            end
            if (mem_rd_en) issued++;
            if (out_valid && out_ready) begin
                if (got < nbeats) begin
                    check_eq($sformatf("%s beat%0d addr", tag, got), 64'(out_addr),
                             64'(exp_addr[got]));
                    check_eq($sformatf("%s beat%0d data", tag, got), 64'(out_data),
                             64'(exp_data[got]));
                    check_eq($sformatf("%s beat%0d last", tag, got), 64'(out_last),
                             64'(got == nbeats - 1));
                end else begin
                    check_eq($sformatf("%s extra beat", tag), 64'(out_addr), 64'(10'h3ff));
                end
                got++;
            end
            if (issued - got > max_out) max_out = issued - got;
            if (done) done_cyc = cyc;
            stalled = out_valid && !out_ready;
            p_addr  = out_addr;
            p_data  = out_data;
            @(negedge clk1);
            cyc++;
        end
        start = 1'b0;
        out_ready = 1'b1;
        check_eq($sformatf("%s done seen", tag), 64'(done_cyc >= 0), 64'(1));
        check_eq($sformatf("%s beat count", tag), 64'(got), 64'(nbeats));
        check_eq($sformatf("%s outstanding<=2", tag), 64'(max_out <= 2), 64'(1));
        if (exp_done >= 0)
            check_eq($sformatf("%s done cycle", tag), 64'(done_cyc), 64'(exp_done));
        #1;
        check_eq($sformatf("%s done pulse", tag), 64'(done), 64'(0));
        check_eq($sformatf("%s busy after", tag), 64'(busy), 64'(0));
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        mem[198] = 32'd5040; mem[199] = 32'd0; mem[200] = 32'd7;
        mem[1023] = 32'hAAAA_0000; mem[0] = 32'h280A_00C8;
        for (int i = 0; i < 8; i++) mem[10+i] = 32'h100 + 32'(i);

        rst_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b1;
        #2;
        check_eq("reset out_valid", 64'(out_valid), 64'(0));
        check_eq("reset busy", 64'(busy), 64'(0));
        check_eq("reset done", 64'(done), 64'(0));
        check_eq("reset mem_rd_en", 64'(mem_rd_en), 64'(0));
        check_eq("reset mem_addr", 64'(mem_addr), 64'(0));
        @(negedge clk1); @(negedge clk1);
        rst_n = 1'b1;

        // Test 1 / 6: Mem[198..200], ready high, ignored start mid-dump
        exp_addr[0] = 10'd198; exp_data[0] = 32'd5040;
        exp_addr[1] = 10'd199; exp_data[1] = 32'd0;
        exp_addr[2] = 10'd200; exp_data[2] = 32'd7;
        exp_addr[3] = 10'd201; exp_data[3] = 32'd5047;
        run_dump("t1", 10'd198, 11'd3, 0, 3 + ChkExtra, 4 + ChkExtra, 1'b1);

        // Test 2: same data under toggling backpressure
        run_dump("t2", 10'd198, 11'd3, 1, 3 + ChkExtra, -1, 1'b1);

        // Test 3: address wrap
        exp_addr[0] = 10'd1023; exp_data[0] = 32'hAAAA_0000;
        exp_addr[1] = 10'd0;    exp_data[1] = 32'h280A_00C8;
        exp_addr[2] = 10'd1;    exp_data[2] = 32'hD2B4_00C8;
        run_dump("t3", 10'd1023, 11'd2, 0, 2 + ChkExtra, 3 + ChkExtra, 1'b0);

        // Test 4: zero-length dump
        exp_addr[0] = 10'd55; exp_data[0] = 32'd0;
        run_dump("t4", 10'd55, 11'd0, 0, ChkExtra, 1, 1'b0);

        // Test 5: reset after two beats of an 8-word dump
        @(negedge clk1);
        start = 1'b1; base_addr = 10'd10; word_count = 11'd8;
        @(negedge clk1);
        start = 1'b0;
        @(negedge clk1);
        @(negedge clk1);
        #1;
        check_eq("t5 pre-reset addr", 64'(out_addr), 64'(11));
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("t5 rst out_valid", 64'(out_valid), 64'(0));
        check_eq("t5 rst out_data", 64'(out_data), 64'(0));
        check_eq("t5 rst out_addr", 64'(out_addr), 64'(0));
        check_eq("t5 rst out_last", 64'(out_last), 64'(0));
        check_eq("t5 rst mem_rd_en", 64'(mem_rd_en), 64'(0));
        check_eq("t5 rst busy", 64'(busy), 64'(0));
        @(negedge clk1);
        rst_n = 1'b1;
        #1;
        check_eq("t5 no done", 64'(done), 64'(0));
        for (int i = 0; i < 8; i++) begin
            exp_addr[i] = 10'(10 + i);
            exp_data[i] = 32'h100 + 32'(i);
        end
        exp_addr[8] = 10'd18; exp_data[8] = 32'h0000_081C;
        run_dump("t5", 10'd10, 11'd8, 0, 8 + ChkExtra, 9 + ChkExtra, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
